// File: rtl/ram_access_unit.sv
// Load/store controller for a word-wide, byte-addressed, little-endian RAM that acts on the falling edge.
// Handles byte/half/word loads with extension, read-modify-write for sub-word stores, and rejects bad accesses.
module ram_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rw,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  // Bit 2 alone marks the write states, so mem_rw is a single flop output.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    RD     = 3'b001,
    RMW_RD = 3'b010,
    WR     = 3'b100,
    RMW_WR = 3'b110
  } state_t;

  state_t state, state_nx;

  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;

  logic                accept;
  logic                req_err;
  logic [ADDR_WIDTH:0] span;
  logic [ADDR_WIDTH:0] last_byte;
  logic [31:0]         shifted;
  logic [31:0]         load_ext;
  logic [31:0]         merged;

  assign req_ready = (state == IDLE);
  assign mem_rw    = state[2];
  assign accept    = req_valid && (state == IDLE);

  always_comb begin
    span = '0;
    case (req_size)
      2'b01:   span = (ADDR_WIDTH+1)'(1);
      2'b10:   span = (ADDR_WIDTH+1)'(3);
      default: span = '0;
    endcase
    last_byte = {1'b0, req_addr} + span;
    req_err = (req_size == 2'b11)
           || (req_size == 2'b01 && req_addr[0])
           || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
           || (last_byte >= (ADDR_WIDTH+1)'(MEM_BYTES));
  end

  always_comb begin
    shifted  = mem_rdata >> {lane_q, 3'b000};
    load_ext = mem_rdata;
    case (size_q)
      2'b00:   load_ext = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = mem_rdata;
    endcase
    merged = mem_rdata;
    if (size_q == 2'b00)
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    else
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept && !req_err) begin
          if (!req_we)               state_nx = RD;
          else if (req_size == 2'b10) state_nx = WR;
          else                        state_nx = RMW_RD;
        end
      end
      RD:      state_nx = IDLE;
      WR:      state_nx = IDLE;
      RMW_RD:  state_nx = RMW_WR;
      RMW_WR:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      size_q     <= '0;
      uns_q      <= 1'b0;
      lane_q     <= '0;
      wdata_q    <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_nx;
      resp_valid <= 1'b0;
      if (accept) begin
        size_q   <= req_size;
        uns_q    <= req_unsigned;
        lane_q   <= req_addr[1:0];
        wdata_q  <= req_wdata;
        mem_addr <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        if (req_err) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else if (req_we && req_size == 2'b10) begin
          mem_wdata <= req_wdata;
        end
      end
      case (state)
        RD: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= load_ext;
        end
        WR, RMW_WR: begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        RMW_RD:  mem_wdata <= merged;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_unit.sv
// Directed bench for ram_access_unit with a falling-edge RAM model and hand-computed expectations.
module tb_ram_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic        mem_rw;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  logic [7:0] ram [64];
  int         wr_cnt = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  ram_access_unit #(.ADDR_WIDTH(32), .MEM_BYTES(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_addr(mem_addr), .mem_rw(mem_rw),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: services the request on the falling edge.
  always @(negedge clk) begin
    if (mem_rw) begin
      wr_cnt = wr_cnt + 1;
      if (mem_addr < 64) begin
        ram[mem_addr]   = mem_wdata[7:0];
        ram[mem_addr+1] = mem_wdata[15:8];
        ram[mem_addr+2] = mem_wdata[23:16];
        ram[mem_addr+3] = mem_wdata[31:24];
      end
    end else if (mem_addr < 64) begin
      mem_rdata = {ram[mem_addr+3], ram[mem_addr+2], ram[mem_addr+1], ram[mem_addr]};
    end
  end

  function automatic logic [31:0] ram_word(input int a);
    return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
    int n;
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; wr_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!exp_err) begin
      check({tag, "/busy"}, 32'(req_ready), 32'd0);
      check({tag, "/maddr"}, mem_addr, {addr[31:2], 2'b00});
    end
    n = 0;
    while (!resp_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/valid"}, 32'(resp_valid), 32'd1);
    check({tag, "/lat"}, 32'(n), 32'(exp_lat));
    check({tag, "/err"}, 32'(resp_err), 32'(exp_err));
    check({tag, "/rdata"}, resp_rdata, exp_rd);
    check({tag, "/writes"}, 32'(wr_cnt), (we && !exp_err) ? 32'd1 : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 8'h00;
    #1;
    check("rst/ready", 32'(req_ready), 32'd1);
    check("rst/rw", 32'(mem_rw), 32'd0);
    check("rst/addr", mem_addr, 32'd0);
    check("rst/wdata", mem_wdata, 32'd0);
    check("rst/valid", 32'(resp_valid), 32'd0);
    check("rst/rdata", resp_rdata, 32'd0);
    check("rst/err", 32'(resp_err), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    do_req("sw8", 1, 2'b10, 0, 32'd8, 32'h11223344, 0, 32'h0, 1);
    check("ram8", {ram[11], ram[10], ram[9], ram[8]}, 32'h11223344);
    do_req("lw8", 0, 2'b10, 0, 32'd8, 32'h0, 0, 32'h11223344, 1);

    do_req("sw4", 1, 2'b10, 0, 32'd4, 32'h80FF7F01, 0, 32'h0, 1);
    do_req("lb7", 0, 2'b00, 0, 32'd7, 32'h0, 0, 32'hFFFFFF80, 1);
    do_req("lbu7", 0, 2'b00, 1, 32'd7, 32'h0, 0, 32'h00000080, 1);
    do_req("lh6", 0, 2'b01, 0, 32'd6, 32'h0, 0, 32'hFFFF80FF, 1);
    do_req("lhu4", 0, 2'b01, 1, 32'd4, 32'h0, 0, 32'h00007F01, 1);
    do_req("lw_uns", 0, 2'b10, 1, 32'd4, 32'h0, 0, 32'h80FF7F01, 1);

    do_req("sb5", 1, 2'b00, 0, 32'd5, 32'h123456AB, 0, 32'h0, 2);
    check("ram4_sb", ram_word(4), 32'h80FFAB01);
    do_req("sh6", 1, 2'b01, 0, 32'd6, 32'h9876CDEF, 0, 32'h0, 2);
    do_req("lw4", 0, 2'b10, 0, 32'd4, 32'h0, 0, 32'hCDEFAB01, 1);
    @(posedge clk); #1;
    check("pulse/valid", 32'(resp_valid), 32'd0);
    check("hold/rdata", resp_rdata, 32'hCDEFAB01);

    do_req("e_lw2", 0, 2'b10, 0, 32'd2, 32'h0, 1, 32'h0, 0);
    do_req("e_lh3", 0, 2'b01, 0, 32'd3, 32'h0, 1, 32'h0, 0);
    do_req("e_sz3", 0, 2'b11, 0, 32'd0, 32'h0, 1, 32'h0, 0);
    do_req("e_lw64", 0, 2'b10, 0, 32'd64, 32'h0, 1, 32'h0, 0);
    do_req("e_sw64", 1, 2'b10, 0, 32'd64, 32'hFFFFFFFF, 1, 32'h0, 0);
    do_req("e_sh63", 1, 2'b01, 0, 32'd62, 32'h0, 0, 32'h0, 2);
    do_req("sw60", 1, 2'b10, 0, 32'd60, 32'hA5A55A5A, 0, 32'h0, 1);
    do_req("lw60", 0, 2'b10, 0, 32'd60, 32'h0, 0, 32'hA5A55A5A, 1);
    do_req("lb63", 0, 2'b00, 0, 32'd63, 32'h0, 0, 32'hFFFFFFA5, 1);

    do_req("b2b_lw8", 0, 2'b10, 0, 32'd8, 32'h0, 0, 32'h11223344, 1);
    do_req("b2b_sw12", 1, 2'b10, 0, 32'd12, 32'hDEADBEEF, 0, 32'h0, 1);
    do_req("b2b_lw12", 0, 2'b10, 0, 32'd12, 32'h0, 0, 32'hDEADBEEF, 1);

    // Reset while in RMW_RD
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'd5; req_wdata = 32'h77;
    wr_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst1/busy", 32'(req_ready), 32'd0);
    reset = 1'b1; #1;
    check("rst1/rw", 32'(mem_rw), 32'd0);
    check("rst1/ready", 32'(req_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst1/novalid", 32'(resp_valid), 32'd0);
    end
    check("rst1/writes", 32'(wr_cnt), 32'd0);
    check("rst1/ram4", ram_word(4), 32'hCDEFAB01);

    // Reset while in RMW_WR, before the falling edge that would write
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'd4; req_wdata = 32'h55;
    wr_cnt = 0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rst2/rw_on", 32'(mem_rw), 32'd1);
    reset = 1'b1; #1;
    check("rst2/rw_off", 32'(mem_rw), 32'd0);
    @(negedge clk); #1;
    check("rst2/writes", 32'(wr_cnt), 32'd0);
    check("rst2/ram4", ram_word(4), 32'hCDEFAB01);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst2/novalid", 32'(resp_valid), 32'd0);
    do_req("post_lw4", 0, 2'b10, 0, 32'd4, 32'h0, 0, 32'hCDEFAB01, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_access_unit.md
Name: ram_access_unit

Overview:
- Initiator-side load/store controller that drives the word-wide, byte-addressed, little-endian data RAM, which services requests on the falling clock edge.
- Sits between the CPU datapath's memory stage and the RAM.
- Accepts byte, halfword and word loads and stores over a valid/ready request port.
- Extracts and sign- or zero-extends load data; performs read-modify-write for sub-word stores; flags misaligned or out-of-range accesses without touching memory.

Parameters:
ADDR_WIDTH, 32, width of request and memory address buses
MEM_BYTES, 64, RAM size in bytes; any access with a byte in [MEM_BYTES, 2^ADDR_WIDTH) is an error

Ports:
clk  in  1  clock; unit registers on rising edge, RAM acts on falling edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads only: 1 zero-extend, 0 sign-extend
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  valid with resp_valid; access rejected
mem_addr  out  ADDR_WIDTH  to RAM addr, always {req_addr[ADDR_WIDTH-1:2],2'b00}
mem_rw  out  1  to RAM rw; 1 = write
mem_wdata  out  32  to RAM i_data
mem_rdata  in  32  from RAM o_data

Behaviour:
- Reset values (asynchronous, all outputs): state IDLE, req_ready=1, mem_rw=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0.
- Reset mid-operation: aborts immediately. mem_rw falls to 0 asynchronously, so no write occurs at the next falling edge. No resp_valid is produced.
- mem_rw is decoded from the state register only. It is 1 only in WR and RMW_WR, and it is glitch-free.
- States: IDLE, RD, WR, RMW_RD, RMW_WR.
- Accept: on a rising edge with req_valid=1 and state IDLE. The request is registered and the edge is called E0.
- Error check at accept:
  - size=11 is an error.
  - half with addr[0]=1 is an error.
  - word with addr[1:0]!=0 is an error.
  - addr+bytes-1 >= MEM_BYTES is an error.
  - On error: stay in IDLE; resp_valid=1, resp_err=1, resp_rdata=0 in the cycle after E0; no RAM write ever issued.
- Load: E0 -> RD (mem_rw=0, mem_addr driven). At E1, capture mem_rdata, extract and extend, go to IDLE. resp_valid=1 in the cycle after E1.
- Word store: E0 -> WR (mem_rw=1, mem_wdata=req_wdata). At E1 -> IDLE. resp_valid=1 in the cycle after E1.
- Byte/half store:
  - E0 -> RMW_RD.
  - E1: capture mem_rdata, merge the new lane(s), -> RMW_WR with mem_wdata=merged.
  - E2 -> IDLE. resp_valid=1 in the cycle after E2.
- Lane mapping:
  - Byte k=addr[1:0] occupies bits [8k+7:8k].
  - Half h=addr[1] occupies bits [16h+15:16h].
  - Untouched lanes are written back unchanged.
- Extension: sign bit is bit 7 (byte) or bit 15 (half); req_unsigned is ignored for words and stores.
- Back-to-back: req_ready is 1 in the same cycle as resp_valid, so a new request can be accepted at the edge that ends the pulse.
- resp_valid lasts exactly one cycle. resp_rdata and resp_err hold their values until the next completion.
- req_* inputs are ignored when not in IDLE.

Test Plan:
- Word store 0x11223344 @8 then word load @8 -> store resp_valid one cycle after E1; RAM bytes [8..11]=44,33,22,11; load returns 0x11223344 in the cycle after E1, resp_err=0.
- Store word 0x80FF7F01 @4, then:
  - lb @7 -> 0xFFFFFF80
  - lbu @7 -> 0x00000080
  - lh @6 -> 0xFFFF80FF
  - lhu @4 -> 0x00007F01
- sb 0x...AB @5, then sh 0x...CDEF @6 over 0x80FF7F01 -> each resp two edges after E0 plus one cycle; mem_rw=1 for exactly one cycle each; lw @4 = 0xCDEFAB01.
- Error cases: lw @2, lh @3, size=11 @0, lw @64 -> each gives resp_err=1, resp_rdata=0 one cycle after accept; mem_rw stays 0 throughout. Control: lw @60 succeeds.
- Reset asserted in RMW_RD of sb @5 -> mem_rw=0 immediately; word @4 unchanged; no resp_valid; req_ready=1 after release.
- Back-to-back: lw @8 immediately followed by sw @12 accepted on the resp_valid cycle -> no idle gap; both complete correctly.
